// File: rtl/if_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_fetch
// Description : Instruction-fetch stage. Owns the PC, picks the next PC
//               (sequential / branch / jump / JR / exception), runs the
//               instruction-memory request/ready handshake and presents the
//               fetched word to IF_ID. Memory wait states and hazard stalls
//               are absorbed without losing or duplicating instructions.
//               Optional macro IF_IRQ_EN adds a level IRQ input and an EPC
//               output.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        JR,
    input  logic [31:0] JR_Target,
    input  logic        Exception,
`ifdef IF_IRQ_EN
    input  logic        IRQ,
    output logic [31:0] EPC,
`endif
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ready,
    input  logic [31:0] IM_Rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_Flush
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_fetch_hit;
    logic        w_valid;

`ifdef IF_IRQ_EN
    logic [31:0] epc_q, epc_d;
    logic        w_irq_take;

    // An IRQ coinciding with an exception is dropped; the exception wins.
    assign w_irq_take = IRQ & ~Exception;
    assign EPC        = epc_q;
`else
    // IRQ_VECTOR has no consumer without the interrupt option.
    logic w_unused_irq_vector;
    assign w_unused_irq_vector = ^IRQ_VECTOR;
`endif

    // Redirect source and target selection, highest priority first.
    always_comb begin
        w_redirect   = 1'b1;
        w_target_raw = 32'h0;
        if (Exception) begin
            w_target_raw = EXC_VECTOR;
`ifdef IF_IRQ_EN
        end else if (w_irq_take) begin
            w_target_raw = IRQ_VECTOR;
`endif
        end else if (JR) begin
            w_target_raw = JR_Target;
        end else if (Jump) begin
            w_target_raw = Jump_Target;
        end else if (Branch_Taken) begin
            w_target_raw = Branch_Target;
        end else begin
            w_redirect   = 1'b0;
        end
    end

    // Word-align every redirect target.
    assign w_target    = w_target_raw & ~32'h3;
    // Natural 32-bit wrap: FFFF_FFFC + 4 -> 0.
    assign w_pc_plus4  = pc_q + 32'd4;
    assign w_fetch_hit = (state_q == ST_FETCH) & IM_Ready;
    assign w_valid     = ~rst & (w_fetch_hit | (state_q == ST_HOLD));

    // Memory-side and IF_ID-side outputs; reset forces an idle bus and a bubble.
    always_comb begin
        IM_Req         = ~rst & (state_q != ST_HOLD);
        IM_Addr        = pc_q;
        IF_PC          = 32'h0;
        IF_Instruction = 32'h0;
        if (w_valid) begin
            IF_PC          = w_pc_plus4;
            IF_Instruction = w_fetch_hit ? IM_Rdata : buf_q;
        end
        IF_Flush = rst | w_redirect | (~Stall & ~w_valid);
    end

    // Next-state logic for the FETCH / HOLD / DISCARD controller.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        redirect_pc_d = redirect_pc_q;
`ifdef IF_IRQ_EN
        epc_d         = epc_q;
        // The interrupted instruction is the one the PC (or pending redirect) names.
        if (w_irq_take) begin
            epc_d = (state_q == ST_DISCARD) ? redirect_pc_q : pc_q;
        end
`endif
        case (state_q)
            ST_FETCH: begin
                if (IM_Ready) begin
                    if (w_redirect) begin
                        pc_d = w_target;
                    end else if (!Stall) begin
                        pc_d = w_pc_plus4;
                    end else begin
                        buf_d   = IM_Rdata;
                        state_d = ST_HOLD;
                    end
                end else if (w_redirect) begin
                    // Address must stay put until memory completes; park the target.
                    redirect_pc_d = w_target;
                    state_d       = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    pc_d    = w_target;
                    state_d = ST_FETCH;
                end else if (!Stall) begin
                    pc_d    = w_pc_plus4;
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (w_redirect) begin
                    redirect_pc_d = w_target;
                end
                if (IM_Ready) begin
                    pc_d    = w_redirect ? w_target : redirect_pc_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            buf_q         <= 32'h0;
            redirect_pc_q <= 32'h0;
`ifdef IF_IRQ_EN
            epc_q         <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            redirect_pc_q <= redirect_pc_d;
`ifdef IF_IRQ_EN
            epc_q         <= epc_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_pc_fetch
// Description : Directed self-checking bench for if_pc_fetch. Inputs change
//               just after the falling edge; outputs are checked 1 ns later,
//               well before the next rising edge. Memory returns
//               address ^ c_KEY when a request is answered, DEAD_BEEF
//               otherwise. Covers IF_IRQ_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_pc_fetch;

    localparam logic [31:0] c_KEY  = 32'h5A5A_0000;
    localparam logic [31:0] c_JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic        JR;
    logic [31:0] JR_Target;
    logic        Exception;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic        IM_Ready;
    logic [31:0] IM_Rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_Flush;
`ifdef IF_IRQ_EN
    logic        IRQ;
    logic [31:0] EPC;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign IM_Rdata = (IM_Req & IM_Ready) ? (IM_Addr ^ c_KEY) : c_JUNK;

    if_pc_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (Stall),
        .Branch_Taken   (Branch_Taken),
        .Branch_Target  (Branch_Target),
        .Jump           (Jump),
        .Jump_Target    (Jump_Target),
        .JR             (JR),
        .JR_Target      (JR_Target),
        .Exception      (Exception),
`ifdef IF_IRQ_EN
        .IRQ            (IRQ),
        .EPC            (EPC),
`endif
        .IM_Req         (IM_Req),
        .IM_Addr        (IM_Addr),
        .IM_Ready       (IM_Ready),
        .IM_Rdata       (IM_Rdata),
        .IF_PC          (IF_PC),
        .IF_Instruction (IF_Instruction),
        .IF_Flush       (IF_Flush)
    );

    task automatic clear_inputs();
        Stall         = 1'b0;
        Branch_Taken  = 1'b0;
        Branch_Target = 32'h0;
        Jump          = 1'b0;
        Jump_Target   = 32'h0;
        JR            = 1'b0;
        JR_Target     = 32'h0;
        Exception     = 1'b0;
        IM_Ready      = 1'b1;
`ifdef IF_IRQ_EN
        IRQ           = 1'b0;
`endif
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        checks++; if (IM_Req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", IM_Req); end
        checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL rst_ifpc got %h exp 0", IF_PC); end
        checks++; if (IF_Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", IF_Instruction); end
        checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b exp 1", IF_Flush); end
        next_cycle();
        rst = 1'b0;
`ifdef IF_IRQ_EN
        #1;
        checks++; if (EPC !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", EPC); end
`endif
    endtask

    // Four back-to-back fetches starting at address 0.
    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            clear_inputs();
            #1;
            checks++; if (IM_Addr !== a) begin errors++; $display("FAIL seq_addr got %h exp %h", IM_Addr, a); end
            checks++; if (IF_PC !== a + 32'd4) begin errors++; $display("FAIL seq_ifpc got %h exp %h", IF_PC, a + 32'd4); end
            checks++; if (IF_Instruction !== (a ^ c_KEY)) begin errors++; $display("FAIL seq_instr got %h exp %h", IF_Instruction, a ^ c_KEY); end
            checks++; if (IF_Flush !== 1'b0) begin errors++; $display("FAIL seq_flush got %b exp 0", IF_Flush); end
            next_cycle();
        end
    endtask

    task automatic deliver_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(i * 4);
            clear_inputs();
            #1;
            checks++; if (IM_Addr !== a) begin errors++; $display("FAIL run_addr got %h exp %h", IM_Addr, a); end
            next_cycle();
        end
    endtask

    // Two wait states on 0x10, then a single delivery of 0x10.
    task automatic test_wait_states();
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            IM_Ready = 1'b0;
            #1;
            checks++; if (IM_Addr !== 32'h10) begin errors++; $display("FAIL wait_addr got %h exp 10", IM_Addr); end
            checks++; if (IM_Req !== 1'b1) begin errors++; $display("FAIL wait_req got %b exp 1", IM_Req); end
            checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL wait_flush got %b exp 1", IF_Flush); end
            next_cycle();
        end
        clear_inputs();
        #1;
        checks++; if (IF_PC !== 32'h14) begin errors++; $display("FAIL wait_ifpc got %h exp 14", IF_PC); end
        checks++; if (IF_Instruction !== (32'h10 ^ c_KEY)) begin errors++; $display("FAIL wait_instr got %h exp %h", IF_Instruction, 32'h10 ^ c_KEY); end
        checks++; if (IF_Flush !== 1'b0) begin errors++; $display("FAIL wait_dflush got %b exp 0", IF_Flush); end
        next_cycle();
        deliver_run(32'h14, 3);
    endtask

    // Stall lands on 0x20: hold it, then deliver once and move to 0x24.
    task automatic test_stall_hold();
        clear_inputs();
        Stall = 1'b1;
        #1;
        checks++; if (IM_Addr !== 32'h20) begin errors++; $display("FAIL stall_addr got %h exp 20", IM_Addr); end
        checks++; if (IF_Flush !== 1'b0) begin errors++; $display("FAIL stall_flush got %b exp 0", IF_Flush); end
        next_cycle();
        Stall = 1'b1;
        #1;
        checks++; if (IM_Req !== 1'b0) begin errors++; $display("FAIL hold_req got %b exp 0", IM_Req); end
        checks++; if (IF_Flush !== 1'b0) begin errors++; $display("FAIL hold_flush got %b exp 0", IF_Flush); end
        checks++; if (IF_Instruction !== (32'h20 ^ c_KEY)) begin errors++; $display("FAIL hold_instr got %h exp %h", IF_Instruction, 32'h20 ^ c_KEY); end
        next_cycle();
        Stall = 1'b0;
        #1;
        checks++; if (IF_PC !== 32'h24) begin errors++; $display("FAIL hold_ifpc got %h exp 24", IF_PC); end
        checks++; if (IF_Instruction !== (32'h20 ^ c_KEY)) begin errors++; $display("FAIL hold_dinstr got %h exp %h", IF_Instruction, 32'h20 ^ c_KEY); end
        checks++; if (IF_Flush !== 1'b0) begin errors++; $display("FAIL hold_dflush got %b exp 0", IF_Flush); end
        next_cycle();
        #1;
        checks++; if (IM_Req !== 1'b1) begin errors++; $display("FAIL hold_rreq got %b exp 1", IM_Req); end
        deliver_run(32'h24, 3);
    endtask

    // Branch while 0x30 is outstanding: address holds, data dropped, then 0x100.
    task automatic test_branch_wait();
        clear_inputs();
        IM_Ready      = 1'b0;
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h100;
        #1;
        checks++; if (IM_Addr !== 32'h30) begin errors++; $display("FAIL brw_addr got %h exp 30", IM_Addr); end
        checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL brw_flush got %b exp 1", IF_Flush); end
        next_cycle();
        clear_inputs();
        IM_Ready = 1'b0;
        #1;
        checks++; if (IM_Addr !== 32'h30) begin errors++; $display("FAIL disc_addr got %h exp 30", IM_Addr); end
        checks++; if (IM_Req !== 1'b1) begin errors++; $display("FAIL disc_req got %b exp 1", IM_Req); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL disc_drop got %b exp 1", IF_Flush); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (IM_Addr !== 32'h100) begin errors++; $display("FAIL disc_new got %h exp 100", IM_Addr); end
        checks++; if (IF_PC !== 32'h104) begin errors++; $display("FAIL disc_ifpc got %h exp 104", IF_PC); end
        next_cycle();
    endtask

    // Exception > JR > Jump > Branch, and target alignment.
    task automatic test_priority();
        clear_inputs();
        Exception = 1'b1; JR = 1'b1; JR_Target = 32'h200;
        Jump = 1'b1; Jump_Target = 32'h400; Branch_Taken = 1'b1; Branch_Target = 32'h300;
        #1;
        checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL pri_flush got %b exp 1", IF_Flush); end
        next_cycle();
        clear_inputs();
        JR = 1'b1; JR_Target = 32'h200; Jump = 1'b1; Jump_Target = 32'h400;
        Branch_Taken = 1'b1; Branch_Target = 32'h500;
        #1;
        checks++; if (IM_Addr !== 32'h8000_0004) begin errors++; $display("FAIL pri_exc got %h exp 80000004", IM_Addr); end
        next_cycle();
        clear_inputs();
        Jump = 1'b1; Jump_Target = 32'h403; Branch_Taken = 1'b1; Branch_Target = 32'h500;
        #1;
        checks++; if (IM_Addr !== 32'h200) begin errors++; $display("FAIL pri_jr got %h exp 200", IM_Addr); end
        next_cycle();
        clear_inputs();
        Branch_Taken = 1'b1; Branch_Target = 32'h502;
        #1;
        checks++; if (IM_Addr !== 32'h400) begin errors++; $display("FAIL pri_jump got %h exp 400", IM_Addr); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (IM_Addr !== 32'h500) begin errors++; $display("FAIL pri_branch got %h exp 500", IM_Addr); end
        next_cycle();
    endtask

    // Sequential fetch wraps from FFFF_FFFC to 0.
    task automatic test_wrap();
        clear_inputs();
        Jump = 1'b1; Jump_Target = 32'hFFFF_FFFC;
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (IM_Addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", IM_Addr); end
        checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL wrap_ifpc got %h exp 0", IF_PC); end
        next_cycle();
        #1;
        checks++; if (IM_Addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", IM_Addr); end
    endtask

    // Redirects while discarding: latest wins, same-cycle redirect beats parked one.
    task automatic test_discard_latest();
        clear_inputs();
        IM_Ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h100;
        next_cycle();
        clear_inputs();
        IM_Ready = 1'b0; Jump = 1'b1; Jump_Target = 32'h600;
        #1;
        checks++; if (IM_Addr !== 32'h0) begin errors++; $display("FAIL late_hold got %h exp 0", IM_Addr); end
        next_cycle();
        clear_inputs();
        next_cycle();
        clear_inputs();
        IM_Ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h700;
        #1;
        checks++; if (IM_Addr !== 32'h600) begin errors++; $display("FAIL late_win got %h exp 600", IM_Addr); end
        next_cycle();
        clear_inputs();
        JR = 1'b1; JR_Target = 32'h800;
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (IM_Addr !== 32'h800) begin errors++; $display("FAIL late_same got %h exp 800", IM_Addr); end
    endtask

    // Redirect overrides a stall in HOLD; no flush while stalled and waiting.
    task automatic test_hold_redirect();
        clear_inputs();
        Stall = 1'b1;
        next_cycle();
        clear_inputs();
        Stall = 1'b1; Jump = 1'b1; Jump_Target = 32'h900;
        #1;
        checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL hredir_flush got %b exp 1", IF_Flush); end
        next_cycle();
        clear_inputs();
        Stall = 1'b1; IM_Ready = 1'b0;
        #1;
        checks++; if (IM_Addr !== 32'h900) begin errors++; $display("FAIL hredir_addr got %h exp 900", IM_Addr); end
        checks++; if (IF_Flush !== 1'b0) begin errors++; $display("FAIL stallwait_flush got %b exp 0", IF_Flush); end
        next_cycle();
    endtask

    // Reset while a request to 0x900 is outstanding restarts at 0.
    task automatic test_reset_midwait();
        clear_inputs();
        IM_Ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (IM_Req !== 1'b0) begin errors++; $display("FAIL rstw_req got %b exp 0", IM_Req); end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++; if (IM_Addr !== 32'h0) begin errors++; $display("FAIL rstw_addr got %h exp 0", IM_Addr); end
        checks++; if (IF_PC !== 32'h4) begin errors++; $display("FAIL rstw_ifpc got %h exp 4", IF_PC); end
        next_cycle();
    endtask

`ifdef IF_IRQ_EN
    task automatic test_irq();
        clear_inputs();
        Jump = 1'b1; Jump_Target = 32'h40;
        next_cycle();
        clear_inputs();
        IRQ = 1'b1;
        #1;
        checks++; if (IF_Flush !== 1'b1) begin errors++; $display("FAIL irq_flush got %b exp 1", IF_Flush); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (EPC !== 32'h40) begin errors++; $display("FAIL irq_epc got %h exp 40", EPC); end
        checks++; if (IM_Addr !== 32'h8000_0008) begin errors++; $display("FAIL irq_addr got %h exp 80000008", IM_Addr); end
        IRQ = 1'b1; Exception = 1'b1;
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (EPC !== 32'h40) begin errors++; $display("FAIL irqexc_epc got %h exp 40", EPC); end
        checks++; if (IM_Addr !== 32'h8000_0004) begin errors++; $display("FAIL irqexc_addr got %h exp 80000004", IM_Addr); end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_hold();
        test_branch_wait();
        test_priority();
        test_wrap();
        test_discard_latest();
        test_hold_redirect();
        test_reset_midwait();
`ifdef IF_IRQ_EN
        test_irq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
